// File: rtl/rca_8.sv
// rca_8: WIDTH-bit ripple-carry adder with a registered output stage.
// A chain of full-adder cells adds A + B + cin, with the carry rippling
// from LSB to MSB. One register bank captures sum, carry-out and signed
// overflow whenever in_valid is high, and holds them otherwise.
// out_valid is a registered copy of in_valid.
module rca_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid
);

  // Combinational result of the ripple chain
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             overflow_next;

  // Output register bank
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic             out_valid_reg;

  // One full-adder cell per bit. Each cell owns its carry-in and carry-out
  // nets, and the next cell picks up the previous cell's carry-out. This
  // keeps the chain from being a single self-referencing vector.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      logic c_in;
      logic c_out;

      if (gi == 0) begin : g_first
        assign c_in = cin;
      end else begin : g_rest
        assign c_in = g_fa[gi-1].c_out;
      end

      assign sum_next[gi] = A[gi] ^ B[gi] ^ c_in;
      assign c_out        = (A[gi] & B[gi]) | (A[gi] & c_in) | (B[gi] & c_in);
    end
  endgenerate

  // The carry out of the MSB cell is the unsigned carry. Signed overflow is
  // the carry into the MSB XOR the carry out of the MSB.
  assign cout_next     = g_fa[WIDTH-1].c_out;
  assign overflow_next = g_fa[WIDTH-1].c_in ^ g_fa[WIDTH-1].c_out;

  // Load the result only on a valid cycle and hold it otherwise, so the
  // operand values on idle cycles never reach the outputs. Reset clears the
  // outputs immediately and takes priority over a valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg      <= sum_next;
        cout_reg     <= cout_next;
        overflow_reg <= overflow_next;
      end
    end
  end

  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign overflow  = overflow_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_rca_8.sv
// tb_rca_8: directed, table-driven bench for rca_8. It adds hand-written
// sequences for asynchronous reset, reset-versus-valid priority and output
// hold on idle cycles.
module tb_rca_8;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             out_valid;

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[11];

  rca_8 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report a mismatch on a single line
  task automatic chk(input string name, input int act, input int exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Check all four outputs against the expected values
  task automatic chk_all(input string tag, input int e_sum, input int e_cout,
                         input int e_ovf, input int e_vld);
    chk({tag, ".sum"}, int'(sum), e_sum);
    chk({tag, ".cout"}, int'(cout), e_cout);
    chk({tag, ".overflow"}, int'(overflow), e_ovf);
    chk({tag, ".out_valid"}, int'(out_valid), e_vld);
  endtask

  // Drive one operand set on the falling edge, then step past the rising edge
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic v);
    @(negedge clk);
    A = a; B = b; cin = c; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    // Expected values worked out by hand: {cout,sum} = a+b+c, and
    // overflow = carry into bit 7 XOR carry out of bit 7
    vecs[0]  = '{8'd120, 8'd240, 1'b0, 8'd104, 1'b1, 1'b0};
    vecs[1]  = '{8'd169, 8'd0,   1'b1, 8'd170, 1'b0, 1'b0}; // B = 256 truncated
    vecs[2]  = '{8'd53,  8'd250, 1'b0, 8'd47,  1'b1, 1'b0};
    vecs[3]  = '{8'd1,   8'd50,  1'b1, 8'd52,  1'b0, 1'b0};
    vecs[4]  = '{8'd50,  8'd100, 1'b0, 8'd150, 1'b0, 1'b1};
    vecs[5]  = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0};
    vecs[6]  = '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b0}; // full ripple
    vecs[7]  = '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
    vecs[8]  = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1};
    vecs[9]  = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b0};
    vecs[10] = '{8'd170, 8'd85,  1'b0, 8'd255, 1'b0, 1'b0};

    A = '0; B = '0; cin = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;

    // Asynchronous reset at power-up, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    $display("reset at t=%0t: sum=%0d cout=%0b ovf=%0b vld=%0b", $time, sum, cout, overflow, out_valid);
    chk_all("init_reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, applied back to back, one per cycle
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);
      $display("vec %0d: %0d+%0d+%0d -> sum=%0d cout=%0b ovf=%0b vld=%0b",
               i, vecs[i].a, vecs[i].b, vecs[i].c, sum, cout, overflow, out_valid);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].exp_sum), int'(vecs[i].exp_cout),
              int'(vecs[i].exp_ovf), 1);
    end

    // Reload a nonzero result, then hold it through idle cycles with changing operands
    apply(8'd255, 8'd255, 1'b1, 1'b1);
    chk_all("preload", 255, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      $display("hold %0d: sum=%0d cout=%0b ovf=%0b vld=%0b", i, sum, cout, overflow, out_valid);
      chk_all($sformatf("hold%0d", i), 255, 1, 0, 0);
    end

    // Mid-operation reset: outputs clear at once, away from any clock edge
    apply(8'd50, 8'd100, 1'b0, 1'b1);
    chk_all("pre_reset", 150, 0, 1, 1);
    @(negedge clk);
    A = 8'd127; B = 8'd1; cin = 1'b0; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    $display("mid reset at t=%0t: sum=%0d cout=%0b ovf=%0b vld=%0b", $time, sum, cout, overflow, out_valid);
    chk_all("mid_reset", 0, 0, 0, 0);

    // Reset beats in_valid at the edge
    @(posedge clk);
    #1;
    chk_all("reset_wins", 0, 0, 0, 0);

    // Release with in_valid low: outputs stay cleared
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("release_idle", 0, 0, 0, 0);

    // First valid operation after reset
    apply(8'd100, 8'd27, 1'b1, 1'b1);
    $display("post reset: 100+27+1 -> sum=%0d cout=%0b ovf=%0b vld=%0b", sum, cout, overflow, out_valid);
    chk_all("post_reset", 128, 0, 1, 1);

    apply(8'd0, 8'd0, 1'b0, 1'b0);
    chk_all("final_idle", 128, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rca_8.md
Name:
rca_8

Overview:
- 8-bit ripple-carry adder with a registered output stage; computes A + B + cin and returns an 8-bit sum, carry-out and signed-overflow flag.
- Datapath is a structural chain of WIDTH full-adder cells (carry ripples LSB to MSB) feeding one output register bank.
- Used as the basic arithmetic building block in the datapath.
- Single clock; asynchronous active-low reset.

Parameters:
- WIDTH, 8, operand and sum width in bits. All test values below assume 8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  unsigned addend A.
- B  input  WIDTH  unsigned addend B.
- cin  input  1  carry-in, added at bit 0.
- in_valid  input  1  qualifies A/B/cin this cycle.
- sum  output  WIDTH  registered (A + B + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of the MSB cell.
- overflow  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  registered copy of in_valid; marks sum/cout/overflow as fresh.

Behaviour:
- Reset: rst_n low clears sum, cout, overflow and out_valid to 0 immediately, without waiting for a clock edge.
- Outputs stay 0 while rst_n is low. Release is synchronous to the next rising clk.
- Full-adder cell i: s_i = A_i ^ B_i ^ c_i; c_{i+1} = A_i&B_i | A_i&c_i | B_i&c_i; c_0 = cin; cout = c_WIDTH.
- The ripple chain is purely combinational. Its only state is the output register.
- Latency is exactly 1 cycle: operands sampled at rising edge N with in_valid=1 appear on the outputs after edge N.
- Throughput is one addition per cycle. There is no backpressure and no stall.
- When in_valid=1 at an edge: sum, cout and overflow load the new result, and out_valid goes to 1.
- When in_valid=0 at an edge: sum, cout and overflow hold their previous values, and out_valid goes to 0.
- Arithmetic is unsigned and modulo 2^WIDTH. The full result is {cout, sum}, range 0 to 2^(WIDTH+1)-1 (0..511 for WIDTH=8).
- Operands wider than WIDTH at the instantiating site are truncated by the parent before reaching the ports. Inside the block, operands are always exactly WIDTH bits.
- overflow is meaningful when A and B are read as signed. It is computed regardless of interpretation.
- If rst_n asserts in the same cycle as in_valid, reset wins: the result is discarded and out_valid stays 0.
- X/Z on inputs while in_valid=0 must not disturb the held outputs.

Test Plan:
- Reset: rst_n=0 mid-operation with outputs nonzero -> sum=0, cout=0, overflow=0, out_valid=0 immediately, before any clk edge.
- A=120, B=240, cin=0, in_valid=1 -> next cycle sum=104, cout=1, overflow=0, out_valid=1.
- A=169, B=0 (a value of 256 truncated to 8 bits), cin=1 -> sum=170, cout=0, overflow=0.
- A=53, B=250, cin=0 -> sum=47, cout=1, overflow=0.
- Back-to-back: cycle 1 A=1, B=50, cin=1; cycle 2 A=50, B=100, cin=0 -> consecutive outputs sum=52, cout=0, overflow=0, then sum=150, cout=0, overflow=1.
- Boundaries and hold:
  - A=255, B=255, cin=1 -> sum=255, cout=1.
  - A=255, B=0, cin=1 -> sum=0, cout=1 (full ripple).
  - Then in_valid=0 with changing A/B -> outputs hold, out_valid=0.
